// File: rtl/serial_feeder_pkg.sv
// Shared types and helpers for the serial word feeder: FSM encoding, default idle level, parity.
// Used by serial_word_feeder (parity path enabled with SERIAL_FEEDER_PARITY_EN).
package serial_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } feeder_state_t;

    localparam logic IDLE_BIT_DEFAULT = 1'b0;

    // Widest word the parity helper covers; narrower words are zero-extended by the caller.
    localparam int PARITY_MAX_W = 64;

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/feeder_hold_buf.sv
// One-word hold buffer for serial_word_feeder: W-bit register plus full flag,
// loaded and unloaded by strobes from the feeder FSM.
module feeder_hold_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] din,
    output logic [W-1:0] hd,
    output logic         full
);

    logic [W-1:0] hd_reg;
    logic         full_reg;
    logic         full_next;

    // A simultaneous load and unload leaves the buffer full with the new word.
    always_comb begin
        full_next = full_reg;
        if (load) begin
            full_next = 1'b1;
        end else if (unload) begin
            full_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hd_reg   <= '0;
            full_reg <= 1'b0;
        end else begin
            full_reg <= full_next;
            if (load) begin
                hd_reg <= din;
            end
        end
    end

    assign hd   = hd_reg;
    assign full = full_reg;

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: valid/ready words shifted out MSB-first with a one-word hold buffer.
// Define SERIAL_FEEDER_PARITY_EN to append an even-parity bit after each word.
module serial_word_feeder
    import serial_feeder_pkg::*;
#(
    parameter int   W        = 8,
    parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         dout,
    output logic         dout_valid,
    output logic         word_start,
    output logic         busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    feeder_state_t state_reg, state_next;
    logic [W-1:0]  sh_reg, sh_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic          hold_full;
    logic [W-1:0]  hold_data;

    logic          last_bit;
    logic          take;
    logic          accept;
    logic          take_hold;
    logic          take_in;
    logic          load_sh;
    logic          hold_load;
    logic [W-1:0]  load_word;

`ifdef SERIAL_FEEDER_PARITY_EN
    logic          par_reg, par_next;
`endif

    assign last_bit = (cnt_reg == CW'(W - 1));
    assign accept   = in_valid && !hold_full;

    // Edges on which the shifter is free to pick up a new word.
    always_comb begin
        take = 1'b0;
        case (state_reg)
            ST_IDLE:   take = 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
            ST_SHIFT:  take = 1'b0;
            ST_PARITY: take = 1'b1;
`else
            ST_SHIFT:  take = last_bit;
`endif
            default:   take = 1'b0;
        endcase
    end

    // The hold word always has priority over a word arriving on the same edge.
    assign take_hold = take && hold_full;
    assign take_in   = take && !hold_full && accept;
    assign load_sh   = take_hold || take_in;
    assign hold_load = accept && (!take || take_hold);
    assign load_word = take_hold ? hold_data : in_data;

    feeder_hold_buf #(
        .W(W)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .load   (hold_load),
        .unload (take_hold),
        .din    (in_data),
        .hd     (hold_data),
        .full   (hold_full)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                state_next = load_sh ? ST_SHIFT : ST_IDLE;
            end
            ST_SHIFT: begin
                if (last_bit) begin
`ifdef SERIAL_FEEDER_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = load_sh ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
`ifdef SERIAL_FEEDER_PARITY_EN
            ST_PARITY: begin
                state_next = load_sh ? ST_SHIFT : ST_IDLE;
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Shift datapath
    always_comb begin
        sh_next  = sh_reg;
        cnt_next = cnt_reg;
        if (load_sh) begin
            sh_next  = load_word;
            cnt_next = '0;
        end else if (state_reg == ST_SHIFT && !last_bit) begin
            sh_next  = {sh_reg[W-2:0], 1'b0};
            cnt_next = cnt_reg + CW'(1);
        end
    end

`ifdef SERIAL_FEEDER_PARITY_EN
    // Parity is fixed when the word enters the shifter, so it survives the shifting.
    always_comb begin
        par_next = par_reg;
        if (load_sh) begin
            par_next = even_parity(PARITY_MAX_W'(load_word));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_reg <= 1'b0;
        end else begin
            par_reg <= par_next;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            sh_reg  <= sh_next;
            cnt_reg <= cnt_next;
        end
    end

    // FSM outputs, decoded from flops only
    always_comb begin
        dout       = IDLE_BIT;
        dout_valid = 1'b0;
        word_start = 1'b0;
        case (state_reg)
            ST_SHIFT: begin
                dout       = sh_reg[W-1];
                dout_valid = 1'b1;
                word_start = (cnt_reg == '0);
            end
`ifdef SERIAL_FEEDER_PARITY_EN
            ST_PARITY: begin
                dout       = par_reg;
                dout_valid = 1'b1;
            end
`endif
            default: begin
                dout       = IDLE_BIT;
                dout_valid = 1'b0;
                word_start = 1'b0;
            end
        endcase
    end

    assign in_ready = !hold_full;
    assign busy     = (state_reg != ST_IDLE) || hold_full;

endmodule
